// File: rtl/save_trailer_mux_if.sv
// Loader, unloader, backup-RAM and trailer-replay signals of save_trailer_mux.
// The slave modport is the mux; the master modport is the surrounding bridge/RAM/RTC side.
interface save_trailer_mux_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16
);
    logic              ld_wr;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] ul_addr;
    logic [DATA_W-1:0] ul_data;
    logic              bk_wr;
    logic [ADDR_W-2:0] bk_addr;
    logic [DATA_W-1:0] bk_data;
    logic [DATA_W-1:0] bk_q;
    logic              tr_valid;
    logic              tr_ready;
    logic [5:0]        tr_idx;
    logic [DATA_W-1:0] tr_data;
    logic              tr_done;

    modport master (
        output ld_wr, ld_addr, ld_data, ul_addr, bk_q, tr_ready,
        input  ul_data, bk_wr, bk_addr, bk_data, tr_valid, tr_idx, tr_data, tr_done
    );

    modport slave (
        input  ld_wr, ld_addr, ld_data, ul_addr, bk_q, tr_ready,
        output ul_data, bk_wr, bk_addr, bk_data, tr_valid, tr_idx, tr_data, tr_done
    );
endinterface

// File: rtl/save_trailer_mux.sv
// Save-path mux: routes save-region traffic to backup RAM, captures a TRAILER_WORDS trailer
// from the loader, serves live trailer words to the unloader and replays the capture to the RTC.
module save_trailer_mux #(
    parameter int unsigned ADDR_W        = 18,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned TRAILER_WORDS = 5
) (
    input  logic                            clk_sys,
    input  logic                            reset_n,
    input  logic                            cart_has_save,
    input  logic [7:0]                      ram_mask,
    input  logic                            rtc_inuse,
    input  logic                            cart_download,
    input  logic [TRAILER_WORDS*DATA_W-1:0] live_trailer,
    output logic [ADDR_W-1:0]               save_size,
    output logic [ADDR_W-1:0]               file_size,
    save_trailer_mux_if.slave               bus
);

    localparam int unsigned WB            = DATA_W / 8;
    localparam int unsigned TRAILER_BYTES = TRAILER_WORDS * WB;
    localparam int unsigned IDX_W         = (TRAILER_WORDS > 1) ? $clog2(TRAILER_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StCollect, StReplay, StDone} state_e;

    logic [ADDR_W-1:0] size_dec;
    logic [ADDR_W-1:0] save_size_q, save_size_d;
    logic [ADDR_W-1:0] file_size_q, file_size_d;

    always_comb begin
        size_dec = '0;
        if (cart_has_save) begin
            case (ram_mask)
                8'h01:   size_dec = ADDR_W'(512);
                8'h03:   size_dec = ADDR_W'(2048);
                8'h0F:   size_dec = ADDR_W'(8192);
                8'h3F:   size_dec = ADDR_W'(32768);
                8'h7F:   size_dec = ADDR_W'(65536);
                8'hFF:   size_dec = ADDR_W'(131072);
                default: size_dec = '0;
            endcase
        end
        save_size_d = size_dec;
        file_size_d = save_size_q + (rtc_inuse ? ADDR_W'(TRAILER_BYTES) : '0);
    end

    // Region split for both the loader and the unloader address.
    logic              ld_in_save, ul_in_save;
    logic [ADDR_W-1:0] ld_k, ul_k;
    logic              ld_kvalid, ul_kvalid;
    logic [IDX_W-1:0]  ld_idx;

    always_comb begin
        ld_in_save = bus.ld_addr < save_size_q;
        ld_k       = (bus.ld_addr - save_size_q) / ADDR_W'(WB);
        ld_kvalid  = ld_k < ADDR_W'(TRAILER_WORDS);
        ld_idx     = ld_k[IDX_W-1:0];
        ul_in_save = bus.ul_addr < save_size_q;
        ul_k       = (bus.ul_addr - save_size_q) / ADDR_W'(WB);
        ul_kvalid  = ul_k < ADDR_W'(TRAILER_WORDS);
    end

    assign bus.bk_wr   = bus.ld_wr & ld_in_save;
    assign bus.bk_addr = bus.ld_wr ? bus.ld_addr[ADDR_W-1:1] : bus.ul_addr[ADDR_W-1:1];
    assign bus.bk_data = bus.ld_data;

    // Unloader path: region/index delayed one cycle so they line up with bk_q.
    logic              ul_save_q, ul_kvalid_q, ul_hold_q;
    logic [IDX_W-1:0]  ul_idx_q;
    logic [DATA_W-1:0] ul_data_q, ul_data_d, live_word;

    always_comb begin
        live_word = '1;
        for (int unsigned i = 0; i < TRAILER_WORDS; i++) begin
            if (ul_idx_q == IDX_W'(i)) live_word = live_trailer[i*DATA_W +: DATA_W];
        end
        if (ul_hold_q)        ul_data_d = ul_data_q;
        else if (ul_save_q)   ul_data_d = bus.bk_q;
        else if (ul_kvalid_q) ul_data_d = live_word;
        else                  ul_data_d = '1;
    end

    // Trailer capture and replay.
    state_e                   state_q, state_d;
    logic [TRAILER_WORDS-1:0] vmask_q, vmask_d;
    logic [5:0]               tr_idx_q, tr_idx_d;
    logic                     tr_valid_q, tr_valid_d;
    logic                     tr_done_q, tr_done_d;
    logic                     trl_wr, trl_we;
    logic [DATA_W-1:0]        trl_q [TRAILER_WORDS];

    assign trl_wr = bus.ld_wr & ~ld_in_save & ld_kvalid;

    always_comb begin
        state_d    = state_q;
        vmask_d    = vmask_q;
        tr_idx_d   = tr_idx_q;
        tr_valid_d = tr_valid_q;
        tr_done_d  = tr_done_q;
        trl_we     = 1'b0;
        if (cart_download) begin
            state_d    = StIdle;
            vmask_d    = '0;
            tr_idx_d   = '0;
            tr_valid_d = 1'b0;
            tr_done_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (trl_wr) begin
                        trl_we          = 1'b1;
                        vmask_d[ld_idx] = 1'b1;
                        state_d         = StCollect;
                    end
                end
                StCollect: begin
                    if (trl_wr) begin
                        trl_we          = 1'b1;
                        vmask_d[ld_idx] = 1'b1;
                    end
                    if (&vmask_q) begin
                        state_d    = StReplay;
                        tr_idx_d   = '0;
                        tr_valid_d = 1'b1;
                    end
                end
                StReplay: begin
                    if (bus.tr_ready) begin
                        if (tr_idx_q == 6'(TRAILER_WORDS - 1)) begin
                            state_d    = StDone;
                            tr_valid_d = 1'b0;
                            tr_done_d  = 1'b1;
                        end else begin
                            tr_idx_d = tr_idx_q + 6'd1;
                        end
                    end
                end
                StDone: begin
                    // A fresh trailer write starts a new capture from an empty mask.
                    if (trl_wr) begin
                        trl_we          = 1'b1;
                        vmask_d         = '0;
                        vmask_d[ld_idx] = 1'b1;
                        state_d         = StCollect;
                        tr_done_d       = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            save_size_q <= '0;
            file_size_q <= '0;
            ul_save_q   <= 1'b0;
            ul_kvalid_q <= 1'b0;
            ul_hold_q   <= 1'b0;
            ul_idx_q    <= '0;
            ul_data_q   <= '0;
            state_q     <= StIdle;
            vmask_q     <= '0;
            tr_idx_q    <= '0;
            tr_valid_q  <= 1'b0;
            tr_done_q   <= 1'b0;
        end else begin
            save_size_q <= save_size_d;
            file_size_q <= file_size_d;
            ul_save_q   <= ul_in_save;
            ul_kvalid_q <= ul_kvalid;
            ul_hold_q   <= bus.ld_wr & ld_in_save;
            ul_idx_q    <= ul_k[IDX_W-1:0];
            ul_data_q   <= ul_data_d;
            state_q     <= state_d;
            vmask_q     <= vmask_d;
            tr_idx_q    <= tr_idx_d;
            tr_valid_q  <= tr_valid_d;
            tr_done_q   <= tr_done_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (trl_we) trl_q[ld_idx] <= bus.ld_data;
    end

    assign save_size    = save_size_q;
    assign file_size    = file_size_q;
    assign bus.ul_data  = ul_data_q;
    assign bus.tr_valid = tr_valid_q;
    assign bus.tr_idx   = tr_idx_q;
    assign bus.tr_data  = trl_q[tr_idx_q[IDX_W-1:0]];
    assign bus.tr_done  = tr_done_q;

endmodule

// File: tb/tb_save_trailer_mux.sv
// Directed bench for save_trailer_mux: size decode, save/trailer reads, capture, replay,
// backpressure and abort by cart_download and by reset.
module tb_save_trailer_mux;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cart_has_save;
    logic [7:0]  ram_mask;
    logic        rtc_inuse;
    logic        cart_download;
    logic [79:0] live_trailer;
    logic [17:0] save_size;
    logic [17:0] file_size;
    logic [15:0] mem [0:131071];

    int tests  = 0;
    int failed = 0;

    save_trailer_mux_if #(.ADDR_W(18), .DATA_W(16)) bus ();

    save_trailer_mux #(.ADDR_W(18), .DATA_W(16), .TRAILER_WORDS(5)) dut (
        .clk_sys       (clk),
        .reset_n       (reset_n),
        .cart_has_save (cart_has_save),
        .ram_mask      (ram_mask),
        .rtc_inuse     (rtc_inuse),
        .cart_download (cart_download),
        .live_trailer  (live_trailer),
        .save_size     (save_size),
        .file_size     (file_size),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Backup RAM: registered read, one-cycle latency.
    always @(posedge clk) begin
        if (bus.bk_wr) mem[bus.bk_addr] <= bus.bk_data;
        bus.bk_q <= mem[bus.bk_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_trl(input int k, input logic [15:0] d);
        bus.ld_wr   = 1'b1;
        bus.ld_addr = 18'(8192 + 2 * k);
        bus.ld_data = d;
        tick();
        bus.ld_wr   = 1'b0;
    endtask

    task automatic rd_ul(input logic [17:0] a, input logic [15:0] exp, input string tag);
        bus.ul_addr = a;
        tick();
        tick();
        chk(tag, 64'(bus.ul_data), 64'(exp));
    endtask

    // Checks a replay from index 'from' to completion at sustained tr_ready.
    task automatic walk(input logic [15:0] base, input int from);
        for (int i = from; i < 5; i++) begin
            chk("replay_valid", 64'(bus.tr_valid), 64'd1);
            chk("replay_idx", 64'(bus.tr_idx), 64'(i));
            chk("replay_data", 64'(bus.tr_data), 64'(base + 16'(i)));
            tick();
        end
        chk("done_flag", 64'(bus.tr_done), 64'd1);
        chk("done_valid", 64'(bus.tr_valid), 64'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ul_data", 64'(bus.ul_data), 64'd0);
        chk("rst_tr_valid", 64'(bus.tr_valid), 64'd0);
        chk("rst_tr_idx", 64'(bus.tr_idx), 64'd0);
        chk("rst_tr_done", 64'(bus.tr_done), 64'd0);
        chk("rst_save_size", 64'(save_size), 64'd0);
        chk("rst_file_size", 64'(file_size), 64'd0);
    endtask

    initial begin
        int ord [5] = '{4, 0, 3, 1, 2};

        reset_n       = 1'b0;
        cart_has_save = 1'b0;
        ram_mask      = 8'h00;
        rtc_inuse     = 1'b0;
        cart_download = 1'b0;
        live_trailer  = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus.ld_wr     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.ul_addr   = '0;
        bus.tr_ready  = 1'b1;
        tick();
        tick();
        chk_reset_vals();

        // Size decode and file-size latency.
        reset_n       = 1'b1;
        cart_has_save = 1'b1;
        ram_mask      = 8'h0F;
        rtc_inuse     = 1'b1;
        tick();
        chk("save_size_0F", 64'(save_size), 64'd8192);
        tick();
        chk("file_size_0F", 64'(file_size), 64'd8202);
        ram_mask  = 8'h05;
        rtc_inuse = 1'b0;
        tick();
        tick();
        chk("save_size_05", 64'(save_size), 64'd0);
        chk("file_size_05", 64'(file_size), 64'd0);
        ram_mask  = 8'h0F;
        rtc_inuse = 1'b1;
        tick();
        tick();

        // Save-region write then read back through backup RAM.
        bus.ld_wr   = 1'b1;
        bus.ld_addr = 18'h1FFE;
        bus.ld_data = 16'hBEEF;
        #1;
        chk("save_bk_wr", 64'(bus.bk_wr), 64'd1);
        chk("save_bk_addr", 64'(bus.bk_addr), 64'h0FFF);
        chk("save_bk_data", 64'(bus.bk_data), 64'hBEEF);
        tick();
        bus.ld_wr = 1'b0;
        #1;
        chk("idle_bk_wr", 64'(bus.bk_wr), 64'd0);
        rd_ul(18'h1FFE, 16'hBEEF, "save_readback");

        // Live trailer reads, including an out-of-range index.
        rd_ul(18'd8192, 16'h1111, "trl_read_0");
        rd_ul(18'd8194, 16'h2222, "trl_read_1");
        rd_ul(18'd8200, 16'h5555, "trl_read_4");
        rd_ul(18'd8202, 16'hFFFF, "trl_read_oob");

        // Out-of-order capture; no replay until the mask is full.
        for (int n = 0; n < 5; n++) begin
            bus.ld_wr   = 1'b1;
            bus.ld_addr = 18'(8192 + 2 * ord[n]);
            bus.ld_data = 16'(16'hA0 + ord[n]);
            #1;
            chk("trl_no_bk_wr", 64'(bus.bk_wr), 64'd0);
            tick();
            bus.ld_wr = 1'b0;
            chk("capture_no_valid", 64'(bus.tr_valid), 64'd0);
        end
        tick();
        walk(16'hA0, 0);

        // Backpressure at index 2, with a trailer write that must be ignored mid-replay.
        wr_trl(0, 16'hB0);
        chk("recapture_done_clr", 64'(bus.tr_done), 64'd0);
        for (int k = 1; k < 5; k++) wr_trl(k, 16'(16'hB0 + k));
        tick();
        chk("bp_idx0", 64'(bus.tr_idx), 64'd0);
        tick();
        chk("bp_idx1", 64'(bus.tr_idx), 64'd1);
        tick();
        bus.tr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold_valid", 64'(bus.tr_valid), 64'd1);
            chk("bp_hold_idx", 64'(bus.tr_idx), 64'd2);
            chk("bp_hold_data", 64'(bus.tr_data), 64'hB2);
            if (c == 1) wr_trl(3, 16'hEEEE);
            else tick();
        end
        bus.tr_ready = 1'b1;
        chk("bp_resume_idx", 64'(bus.tr_idx), 64'd2);
        tick();
        walk(16'hB0, 3);

        // Abort via cart_download at index 1.
        for (int k = 0; k < 5; k++) wr_trl(k, 16'(16'hC0 + k));
        tick();
        tick();
        chk("abort_pre_idx", 64'(bus.tr_idx), 64'd1);
        cart_download = 1'b1;
        tick();
        cart_download = 1'b0;
        chk("abort_valid", 64'(bus.tr_valid), 64'd0);
        chk("abort_done", 64'(bus.tr_done), 64'd0);
        chk("abort_idx", 64'(bus.tr_idx), 64'd0);
        for (int k = 0; k < 4; k++) wr_trl(k, 16'(16'hD0 + k));
        tick();
        tick();
        tick();
        chk("abort_mask_cleared", 64'(bus.tr_valid), 64'd0);
        wr_trl(4, 16'hD4);
        tick();
        walk(16'hD0, 0);

        // Abort via reset at index 1.
        for (int k = 0; k < 5; k++) wr_trl(k, 16'(16'hE0 + k));
        tick();
        tick();
        chk("rst_abort_pre_idx", 64'(bus.tr_idx), 64'd1);
        reset_n = 1'b0;
        tick();
        chk_reset_vals();
        reset_n = 1'b1;
        tick();
        chk("post_rst_done", 64'(bus.tr_done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
